// File: rtl/alu_result_checker.sv
// alu_result_checker: response-side checker for the pipelined ALU.
// It computes the golden {co,Y} for each operand set as it is issued and
// delays that value by the ALU latency. It compares the delayed value with
// the live ALU outputs, counts passes and failures (both saturating), and
// holds a sticky record of the first mismatch.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   in_valid, A, B,   : operand set issued to the ALU this cycle
//   opcode
//   Y, co             : live ALU result and carry/borrow out
//   clear             : synchronous clear of counters and failure record
//   chk_valid         : a comparison happens this cycle (combinational)
//   mismatch          : this cycle's comparison failed (combinational)
//   pass_cnt,fail_cnt : saturating comparison counters
//   failed            : sticky, at least one mismatch since reset/clear
//   fail_idx, fail_op : issue index and opcode of the first failure
//   fail_exp,fail_got : expected and observed {co,Y} at the first failure
module alu_result_checker #(
   parameter int unsigned nbits = 7,
   parameter int unsigned pipe  = 2,
   parameter int unsigned cntw  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [nbits:0]   A,
   input  logic [nbits:0]   B,
   input  logic [2:0]       opcode,
   input  logic [nbits+1:0] Y,
   input  logic             co,
   input  logic             clear,
   output logic             chk_valid,
   output logic             mismatch,
   output logic [cntw-1:0]  pass_cnt,
   output logic [cntw-1:0]  fail_cnt,
   output logic             failed,
   output logic [cntw-1:0]  fail_idx,
   output logic [2:0]       fail_op,
   output logic [nbits+2:0] fail_exp,
   output logic [nbits+2:0] fail_got
);

   localparam int unsigned YW = nbits + 2;
   localparam int unsigned EW = nbits + 3;

   typedef enum logic {S_CLEAN, S_FAILED} state_t;

   // Golden model of the ALU, evaluated on the operands at issue
   logic [YW-1:0] w_gold_y;
   logic          w_gold_co;

   always_comb begin
      w_gold_y  = '0;
      w_gold_co = 1'b0;
      case (opcode)
         3'b000: begin
            w_gold_y  = {1'b0, A} + {1'b0, B};
            w_gold_co = w_gold_y[YW-1];
         end
         3'b001: begin
            w_gold_y  = {1'b0, A} - {1'b0, B};
            w_gold_co = (A < B);
         end
         3'b010: w_gold_y = {1'b0, A & B};
         3'b011: w_gold_y = {1'b0, A | B};
         3'b100: w_gold_y = {1'b0, A ^ B};
         3'b101: w_gold_y = {1'b0, ~A};
         3'b110: begin
            w_gold_y  = {A, 1'b0};
            w_gold_co = A[nbits];
         end
         3'b111: begin
            w_gold_y  = {2'b00, A[nbits:1]};
            w_gold_co = A[0];
         end
      endcase
   end

   // Issue index; clear leaves it alone since it tags in-flight entries
   logic [cntw-1:0] r_idx;

   always_ff @(posedge clk) begin
      if (rst)
         r_idx <= '0;
      else if (in_valid)
         r_idx <= r_idx + cntw'(1);
   end

   // Output of the delay line (or the issue point itself when pipe is 0)
   logic            w_lv;
   logic [2:0]      w_lop;
   logic            w_lco;
   logic [YW-1:0]   w_ly;
   logic [cntw-1:0] w_lix;

   generate
      if (pipe == 0) begin : g_comb
         assign w_lv  = in_valid;
         assign w_lop = opcode;
         assign w_lco = w_gold_co;
         assign w_ly  = w_gold_y;
         assign w_lix = r_idx;
      end else begin : g_line
         logic [pipe-1:0] r_v;
         logic [2:0]      r_op [pipe];
         logic            r_co [pipe];
         logic [YW-1:0]   r_y  [pipe];
         logic [cntw-1:0] r_ix [pipe];

         // Valid bits only: reset drops every in-flight entry
         always_ff @(posedge clk) begin
            if (rst) begin
               r_v <= '0;
            end else begin
               r_v[0] <= in_valid;
               for (int i = 1; i < int'(pipe); i++)
                  r_v[i] <= r_v[i-1];
            end
         end

         // Payload shifts unconditionally; it is qualified by r_v
         always_ff @(posedge clk) begin
            r_op[0] <= opcode;
            r_co[0] <= w_gold_co;
            r_y[0]  <= w_gold_y;
            r_ix[0] <= r_idx;
            for (int i = 1; i < int'(pipe); i++) begin
               r_op[i] <= r_op[i-1];
               r_co[i] <= r_co[i-1];
               r_y[i]  <= r_y[i-1];
               r_ix[i] <= r_ix[i-1];
            end
         end

         assign w_lv  = r_v[pipe-1];
         assign w_lop = r_op[pipe-1];
         assign w_lco = r_co[pipe-1];
         assign w_ly  = r_y[pipe-1];
         assign w_lix = r_ix[pipe-1];
      end
   endgenerate

   // Compare point
   logic [EW-1:0] w_got;
   logic [EW-1:0] w_exp;

   assign w_got     = {co, Y};
   assign w_exp     = {w_lco, w_ly};
   assign chk_valid = w_lv;
   assign mismatch  = w_lv & (w_got != w_exp);

   // Counters and first-failure record
   state_t          r_state;
   logic [cntw-1:0] r_pass;
   logic [cntw-1:0] r_fail;
   logic [cntw-1:0] r_fidx;
   logic [2:0]      r_fop;
   logic [EW-1:0]   r_fexp;
   logic [EW-1:0]   r_fgot;

   always_ff @(posedge clk) begin
      // Reset and clear act identically here; clear also beats a same-cycle compare
      if (rst || clear) begin
         r_state <= S_CLEAN;
         r_pass  <= '0;
         r_fail  <= '0;
         r_fidx  <= '0;
         r_fop   <= '0;
         r_fexp  <= '0;
         r_fgot  <= '0;
      end else if (chk_valid) begin
         if (mismatch) begin
            if (r_fail != '1)
               r_fail <= r_fail + cntw'(1);
            if (r_state == S_CLEAN) begin
               r_state <= S_FAILED;
               r_fidx  <= w_lix;
               r_fop   <= w_lop;
               r_fexp  <= w_exp;
               r_fgot  <= w_got;
            end
         end else if (r_pass != '1) begin
            r_pass <= r_pass + cntw'(1);
         end
      end
   end

   assign pass_cnt = r_pass;
   assign fail_cnt = r_fail;
   assign failed   = (r_state == S_FAILED);
   assign fail_idx = r_fidx;
   assign fail_op  = r_fop;
   assign fail_exp = r_fexp;
   assign fail_got = r_fgot;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: two instances (pipe=2/cntw=16 and
// pipe=0/cntw=4) share the operand stream. A history-based reference model
// predicts every cycle's compare outcome and the counter/record state.
module tb_alu_result_checker;

   localparam int HN = 2048;

   logic clk = 1'b1;
   always #5 clk = ~clk;

   logic       rst, in_valid, clear;
   logic [7:0] A, B;
   logic [2:0] opcode;
   logic [8:0] y1, y0;
   logic       co1, co0;

   logic        cv1, mm1, fl1;
   logic [15:0] pc1, fc1, fi1;
   logic [2:0]  fo1;
   logic [9:0]  fe1, fg1;
   logic        cv0, mm0, fl0;
   logic [3:0]  pc0, fc0, fi0;
   logic [2:0]  fo0;
   logic [9:0]  fe0, fg0;

   alu_result_checker #(.nbits(7), .pipe(2), .cntw(16)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
      .Y(y1), .co(co1), .clear(clear), .chk_valid(cv1), .mismatch(mm1),
      .pass_cnt(pc1), .fail_cnt(fc1), .failed(fl1), .fail_idx(fi1),
      .fail_op(fo1), .fail_exp(fe1), .fail_got(fg1));

   alu_result_checker #(.nbits(7), .pipe(0), .cntw(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
      .Y(y0), .co(co0), .clear(clear), .chk_valid(cv0), .mismatch(mm0),
      .pass_cnt(pc0), .fail_cnt(fc0), .failed(fl0), .fail_idx(fi0),
      .fail_op(fo0), .fail_exp(fe0), .fail_got(fg0));

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Per-cycle input history
   bit hv[HN];
   bit hrst[HN];
   bit hclr[HN];
   int hexp[HN];
   int hop[HN];
   int hidx[2][HN];
   int ysched[int];

   // Model state per instance (0: pipe=0, 1: pipe=2)
   int m_pass[2], m_fail[2], m_fidx[2], m_fop[2], m_fexp[2], m_fgot[2], m_idx[2];
   bit m_failed[2], m_init[2];

   // Golden {co,Y} for 8-bit operands, as a 10-bit integer
   function automatic int golden(input int op, input int a, input int b);
      int y, c;
      y = 0;
      c = 0;
      case (op)
         0: begin y = a + b; c = y / 256; end
         1: begin y = (a - b + 512) % 512; c = (a < b) ? 1 : 0; end
         2: y = a & b;
         3: y = a | b;
         4: y = a ^ b;
         5: y = 255 - a;
         6: begin y = (a * 2) % 512; c = a / 128; end
         7: begin y = a / 2; c = a % 2; end
         default: y = 0;
      endcase
      return c * 512 + y;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
      end
   endtask

   task automatic check_dut(input int d, input logic cv, input logic mm,
                            input logic [31:0] pc, input logic [31:0] fc, input logic fl,
                            input logic [31:0] fi, input logic [31:0] fo,
                            input logic [31:0] fe, input logic [31:0] fg, input int got);
      int p, c, e, mx;
      bit ev, em;
      p  = (d == 0) ? 0 : 2;
      mx = (d == 0) ? 15 : 65535;
      c  = cyc;
      ev = (c >= p) && hv[c-p];
      for (int k = c - p; k < c; k++)
         if (k >= 0 && hrst[k]) ev = 0;
      e  = ev ? hexp[c-p] : 0;
      em = ev && (got != e);
      if (m_init[d]) begin
         chk($sformatf("dut%0d chk_valid", d), 32'(cv), 32'(ev));
         chk($sformatf("dut%0d mismatch", d), 32'(mm), 32'(em));
         chk($sformatf("dut%0d pass_cnt", d), pc, m_pass[d]);
         chk($sformatf("dut%0d fail_cnt", d), fc, m_fail[d]);
         chk($sformatf("dut%0d failed", d), 32'(fl), 32'(m_failed[d]));
         chk($sformatf("dut%0d fail_idx", d), fi, m_fidx[d]);
         chk($sformatf("dut%0d fail_op", d), fo, m_fop[d]);
         chk($sformatf("dut%0d fail_exp", d), fe, m_fexp[d]);
         chk($sformatf("dut%0d fail_got", d), fg, m_fgot[d]);
      end
      if (hrst[c] || hclr[c]) begin
         m_pass[d] = 0; m_fail[d] = 0; m_failed[d] = 0;
         m_fidx[d] = 0; m_fop[d] = 0; m_fexp[d] = 0; m_fgot[d] = 0;
         if (hrst[c]) m_init[d] = 1;
      end else if (ev) begin
         if (em) begin
            if (m_fail[d] < mx) m_fail[d]++;
            if (!m_failed[d]) begin
               m_failed[d] = 1;
               m_fidx[d] = hidx[d][c-p];
               m_fop[d]  = hop[c-p];
               m_fexp[d] = e;
               m_fgot[d] = got;
            end
         end else if (m_pass[d] < mx) begin
            m_pass[d]++;
         end
      end
      if (hrst[c]) m_idx[d] = 0;
      else if (hv[c]) m_idx[d] = (m_idx[d] + 1) % (mx + 1);
   endtask

   // Compare process: once per cycle, away from the active edge
   always @(negedge clk) begin
      if (cyc >= HN) begin
         $display("FAIL history overflow at cycle %0d", cyc);
         $fatal(1);
      end
      hv[cyc]   = in_valid;
      hrst[cyc] = rst;
      hclr[cyc] = clear;
      hop[cyc]  = int'(opcode);
      hexp[cyc] = golden(int'(opcode), int'(A), int'(B));
      hidx[0][cyc] = m_idx[0];
      hidx[1][cyc] = m_idx[1];
      check_dut(0, cv0, mm0, 32'(pc0), 32'(fc0), fl0, 32'(fi0), 32'(fo0), 32'(fe0), 32'(fg0),
                int'({co0, y0}));
      check_dut(1, cv1, mm1, 32'(pc1), 32'(fc1), fl1, 32'(fi1), 32'(fo1), 32'(fe1), 32'(fg1),
                int'({co1, y1}));
   end

   // One cycle of stimulus; got < 0 means the ALU answers correctly
   task automatic step(input bit iv, input int op, input int a, input int b,
                       input int got, input bit r, input bit cl);
      int g, v;
      in_valid = iv;
      opcode   = 3'(op);
      A        = 8'(a);
      B        = 8'(b);
      rst      = r;
      clear    = cl;
      g = golden(op & 7, a & 255, b & 255);
      v = (got < 0) ? g : got;
      if (iv) ysched[cyc+2] = v;
      {co0, y0} = iv ? 10'(v) : 10'($urandom);
      {co1, y1} = ysched.exists(cyc) ? 10'(ysched[cyc]) : 10'($urandom);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, -1, 0, 0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, -1, 1, 0);
   endtask

   initial begin
      do_reset();
      do_reset();

      // add 200+100 answered with the literal 9'h12C, co=1
      step(1, 0, 200, 100, 'h32C, 0, 0);
      idle(2);
      chk("t1 pass_cnt", 32'(pc1), 1);
      chk("t1 fail_cnt", 32'(fc1), 0);

      // sub 5-9 answered with co wrong
      do_reset();
      step(1, 1, 5, 9, 'h1FC, 0, 0);
      idle(2);
      chk("t2 failed", 32'(fl1), 1);
      chk("t2 fail_op", 32'(fo1), 1);
      chk("t2 fail_exp", 32'(fe1), 'h3FC);
      chk("t2 fail_got", 32'(fg1), 'h1FC);
      chk("t2 fail_idx", 32'(fi1), 0);
      chk("t2 dut0 fail_exp", 32'(fe0), 'h3FC);

      // second bad op leaves the record frozen
      step(1, 6, 'h81, 0, 0, 0, 0);
      idle(2);
      chk("t4 fail_cnt", 32'(fc1), 2);
      chk("t4 fail_exp frozen", 32'(fe1), 'h3FC);
      chk("t4 fail_op frozen", 32'(fo1), 1);

      // clear coincides with a third mismatch
      step(1, 2, 'h0F, 'hF0, 'h155, 0, 0);
      idle(1);
      step(0, 0, 0, 0, -1, 0, 1);
      chk("t4 clear fail_cnt", 32'(fc1), 0);
      chk("t4 clear failed", 32'(fl1), 0);
      chk("t4 clear fail_exp", 32'(fe1), 0);

      // issues at relative cycles 0, 2, 3 with bubbles
      do_reset();
      step(1, 3, 'h12, 'h34, -1, 0, 0);
      idle(1);
      step(1, 4, 'hAA, 'h55, -1, 0, 0);
      step(1, 7, 'h81, 0, -1, 0, 0);
      idle(3);
      chk("t3 pass_cnt", 32'(pc1), 3);

      // reset drops in-flight entries; next op is tagged 0
      do_reset();
      step(1, 0, 1, 2, -1, 0, 0);
      step(1, 0, 3, 4, -1, 1, 0);
      idle(3);
      chk("t5 pass_cnt", 32'(pc1), 0);
      chk("t5 fail_cnt", 32'(fc1), 0);
      step(1, 7, 'h55, 0, 0, 0, 0);
      idle(2);
      chk("t5 failed", 32'(fl1), 1);
      chk("t5 fail_idx", 32'(fi1), 0);

      // randomized traffic with injected errors, clears and resets
      do_reset();
      repeat (300) begin
         int gv;
         gv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : -1;
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), gv,
              $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
      end

      // saturation at 4 bits and index wrap
      do_reset();
      repeat (20) step(1, 4, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1, 0, 0);
      idle(2);
      chk("t6 dut0 pass_cnt sat", 32'(pc0), 'hF);
      chk("t6 dut1 pass_cnt", 32'(pc1), 20);
      step(1, 5, 'h3C, 0, 0, 0, 0);
      idle(2);
      chk("t6 dut0 fail_idx wrap", 32'(fi0), 4);
      chk("t6 dut1 fail_idx", 32'(fi1), 20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
